// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU opcodes, default widths and the ID/EX bundle.
package pipe_pkg;

    localparam int DW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_LESS = 4'b1000;
    localparam logic [3:0] ALU_NOR  = 4'b1001;
    localparam logic [3:0] ALU_SLLV = 4'b1010;
    localparam logic [3:0] ALU_SRLV = 4'b1011;
    localparam logic [3:0] ALU_SRAV = 4'b1100;

    typedef struct packed {
        logic              valid;
        logic [3:0]        alu_ctrl;
        logic [4:0]        shamt;
        logic [RW_DEF-1:0] rs;
        logic [RW_DEF-1:0] rt;
        logic [DW_DEF-1:0] rs_data;
        logic [DW_DEF-1:0] rt_data;
        logic [DW_DEF-1:0] imm;
        logic              use_imm;
        logic [RW_DEF-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } idex_t;

    // All-zero bundle: invalid, NOP opcode, no side effects.
    localparam idex_t IDEX_BUBBLE = '0;

endpackage

// File: rtl/ex_issue_stage_if.sv
// ID -> EX issue bus: decoded instruction, forwarding sources and EX-side results.
interface ex_issue_stage_if #(
    parameter int DW = 32,
    parameter int RW = 5
);
    logic          id_valid;
    logic [3:0]    id_alu_ctrl;
    logic [4:0]    id_shamt;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [DW-1:0] id_rs_data;
    logic [DW-1:0] id_rt_data;
    logic [DW-1:0] id_imm;
    logic          id_use_imm;
    logic [RW-1:0] id_rd;
    logic          id_reg_write;
    logic          id_mem_read;
    logic          id_mem_write;

    logic          flush;
    logic          exmem_reg_write;
    logic [RW-1:0] exmem_rd;
    logic [DW-1:0] exmem_result;
    logic          memwb_reg_write;
    logic [RW-1:0] memwb_rd;
    logic [DW-1:0] memwb_result;

    logic          stall;
    logic          ex_valid;
    logic [3:0]    ex_alu_ctrl;
    logic [4:0]    ex_shamt;
    logic [DW-1:0] ex_in1;
    logic [DW-1:0] ex_in2;
    logic [DW-1:0] ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_reg_write;
    logic          ex_mem_read;
    logic          ex_mem_write;
    logic [31:0]   stall_count;

    modport master (
        output id_valid, id_alu_ctrl, id_shamt, id_rs, id_rt, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, id_mem_write,
               flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  stall, ex_valid, ex_alu_ctrl, ex_shamt, ex_in1, ex_in2, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, stall_count
    );

    modport slave (
        input  id_valid, id_alu_ctrl, id_shamt, id_rs, id_rt, id_rs_data, id_rt_data,
               id_imm, id_use_imm, id_rd, id_reg_write, id_mem_read, id_mem_write,
               flush, exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output stall, ex_valid, ex_alu_ctrl, ex_shamt, ex_in1, ex_in2, ex_store_data,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, stall_count
    );
endinterface

// File: rtl/fwd_mux.sv
// One operand's forwarding select: EX/MEM beats MEM/WB beats the register-file value.
module fwd_mux #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx,
    input  logic [DW-1:0] reg_data,
    input  logic          exmem_reg_write,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_reg_write,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] data
);
    logic hit_exmem, hit_memwb;

    // $zero is hardwired, so a pending write to r0 must never leak through.
    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == idx);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == idx);

    always_comb begin
        data = reg_data;
        if (hit_exmem)      data = exmem_result;
        else if (hit_memwb) data = memwb_result;
    end
endmodule

// File: rtl/ex_issue_stage.sv
// ID/EX pipeline register with load-use stall, flush and forwarded ALU operand select.
module ex_issue_stage
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input logic             clk,
    input logic             reset,
    ex_issue_stage_if.slave bus
);
    idex_t         cur, nxt, id_fields;
    logic          stall;
    logic [31:0]   stall_count;
    logic [DW-1:0] fwd_rs, fwd_rt;

    always_comb begin
        id_fields           = IDEX_BUBBLE;
        id_fields.valid     = bus.id_valid;
        id_fields.alu_ctrl  = bus.id_alu_ctrl;
        id_fields.shamt     = bus.id_shamt;
        id_fields.rs        = bus.id_rs;
        id_fields.rt        = bus.id_rt;
        id_fields.rs_data   = bus.id_rs_data;
        id_fields.rt_data   = bus.id_rt_data;
        id_fields.imm       = bus.id_imm;
        id_fields.use_imm   = bus.id_use_imm;
        id_fields.rd        = bus.id_rd;
        id_fields.reg_write = bus.id_reg_write;
        id_fields.mem_read  = bus.id_mem_read;
        id_fields.mem_write = bus.id_mem_write;
    end

    // rt only matters as a source when it feeds the ALU or is the store data.
    assign stall = bus.id_valid && cur.valid && cur.mem_read && (cur.rd != '0) &&
                   ((cur.rd == bus.id_rs) ||
                    ((cur.rd == bus.id_rt) && (!bus.id_use_imm || bus.id_mem_write)));

    always_comb begin
        nxt = id_fields;
        if (bus.flush)  nxt = IDEX_BUBBLE;
        else if (stall) nxt = IDEX_BUBBLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur <= IDEX_BUBBLE;
        else        cur <= nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall && !bus.flush && (stall_count != 32'hFFFF_FFFF))
            stall_count <= stall_count + 32'd1;
    end

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx             (cur.rs),
        .reg_data        (cur.rs_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data            (fwd_rs)
    );

    fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx             (cur.rt),
        .reg_data        (cur.rt_data),
        .exmem_reg_write (bus.exmem_reg_write),
        .exmem_rd        (bus.exmem_rd),
        .exmem_result    (bus.exmem_result),
        .memwb_reg_write (bus.memwb_reg_write),
        .memwb_rd        (bus.memwb_rd),
        .memwb_result    (bus.memwb_result),
        .data            (fwd_rt)
    );

    assign bus.stall         = stall;
    assign bus.stall_count   = stall_count;
    assign bus.ex_valid      = cur.valid;
    assign bus.ex_alu_ctrl   = cur.alu_ctrl;
    assign bus.ex_shamt      = cur.shamt;
    assign bus.ex_in1        = fwd_rs;
    assign bus.ex_in2        = cur.use_imm ? cur.imm : fwd_rt;
    assign bus.ex_store_data = fwd_rt;
    assign bus.ex_rd         = cur.rd;
    assign bus.ex_reg_write  = cur.reg_write;
    assign bus.ex_mem_read   = cur.mem_read;
    assign bus.ex_mem_write  = cur.mem_write;
endmodule

// File: tb/tb_ex_issue_stage.sv
// Directed checks of the ID/EX stage: reset, forwarding priority, r0 guard, load-use, flush.
module tb_ex_issue_stage;
    logic clk;
    logic reset;
    int   errors;
    int   checks;

    ex_issue_stage_if #(.DW(32), .RW(5)) bus ();

    ex_issue_stage #(.DW(32), .RW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic id_set(input logic valid, input logic [3:0] op, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [31:0] rs_d, input logic [31:0] rt_d,
                          input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                          input logic rw, input logic mr, input logic mw);
        bus.id_valid     = valid;
        bus.id_alu_ctrl  = op;
        bus.id_shamt     = 5'd0;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rs_data   = rs_d;
        bus.id_rt_data   = rt_d;
        bus.id_imm       = imm;
        bus.id_use_imm   = use_imm;
        bus.id_rd        = rd;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_mem_write = mw;
    endtask

    task automatic fwd_clear();
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = 5'd0;
        bus.exmem_result    = 32'd0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_result    = 32'd0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.flush = 1'b0;
        fwd_clear();
        // Random ID traffic while held in reset
        id_set(1'b1, 4'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
               $urandom, 1'b0, 5'($urandom | 1), 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        chk("rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_stall_count", bus.stall_count, 32'd0);
        chk("rst_ctrl", {29'd0, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, 32'd0);

        // Release: ADD rs=3 rt=4 rd=7
        id_set(1'b1, 4'b0001, 5'd3, 5'd4, 32'h100, 32'h200, 32'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        bus.id_shamt = 5'd9;
        reset = 1'b1;
        tick();
        chk("load_valid", 32'(bus.ex_valid), 32'd1);
        chk("load_alu_ctrl", 32'(bus.ex_alu_ctrl), 32'd1);
        chk("load_shamt", 32'(bus.ex_shamt), 32'd9);
        chk("load_rd", 32'(bus.ex_rd), 32'd7);
        chk("load_in1", bus.ex_in1, 32'h100);
        chk("load_in2", bus.ex_in2, 32'h200);

        // Forwarding priority on the held ADD
        bus.id_valid = 1'b0;
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'h11;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'h22;
        #1;
        chk("fwd_exmem_prio", bus.ex_in1, 32'h11);
        chk("fwd_rt_untouched", bus.ex_store_data, 32'h200);
        bus.exmem_reg_write = 1'b0;
        #1;
        chk("fwd_memwb", bus.ex_in1, 32'h22);
        bus.memwb_rd = 5'd4; bus.memwb_result = 32'h33;
        #1;
        chk("fwd_rt_memwb", bus.ex_in2, 32'h33);
        chk("fwd_store_memwb", bus.ex_store_data, 32'h33);
        fwd_clear();

        // Register-0 guard
        id_set(1'b1, 4'b0001, 5'd0, 5'd4, 32'd0, 32'h44, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hDEAD;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'hBEEF;
        #1;
        chk("r0_guard", bus.ex_in1, 32'd0);
        fwd_clear();

        // Load-use: LW rd=5 then SUB rs=5
        id_set(1'b1, 4'b0001, 5'd1, 5'd5, 32'h10, 32'd0, 32'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 4'b0100, 5'd5, 5'd6, 32'h50, 32'h60, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu_bubble_alu", 32'(bus.ex_alu_ctrl), 32'd0);
        chk("lu_stall_count", bus.stall_count, 32'd1);
        chk("lu_stall_drop", 32'(bus.stall), 32'd0);
        tick();
        chk("lu_sub_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu_sub_alu", 32'(bus.ex_alu_ctrl), 32'd4);
        chk("lu_sub_rd", 32'(bus.ex_rd), 32'd8);

        // Immediate path: SW rt=5 stalls, ADDI rt=5 does not
        id_set(1'b1, 4'b0001, 5'd1, 5'd5, 32'h10, 32'd0, 32'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 4'b0001, 5'd2, 5'd5, 32'h20, 32'h55, 32'd8, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sw_stall", 32'(bus.stall), 32'd1);
        id_set(1'b1, 4'b0001, 5'd2, 5'd5, 32'h20, 32'h55, 32'hFFFF_FFFC, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("addi_no_stall", 32'(bus.stall), 32'd0);
        tick();
        chk("addi_valid", 32'(bus.ex_valid), 32'd1);
        chk("addi_in2", bus.ex_in2, 32'hFFFF_FFFC);
        chk("addi_in1", bus.ex_in1, 32'h20);
        chk("addi_count", bus.stall_count, 32'd1);

        // Load with rd=0 never stalls
        id_set(1'b1, 4'b0001, 5'd1, 5'd0, 32'h10, 32'd0, 32'd4, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 4'b0100, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("rd0_no_stall", 32'(bus.stall), 32'd0);

        // Flush together with load-use
        id_set(1'b1, 4'b0001, 5'd1, 5'd5, 32'h10, 32'd0, 32'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 4'b0100, 5'd5, 5'd6, 32'h50, 32'h60, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall_seen", 32'(bus.stall), 32'd1);
        tick();
        bus.flush = 1'b0;
        chk("flush_bubble", 32'(bus.ex_valid), 32'd0);
        chk("flush_rw", 32'(bus.ex_reg_write), 32'd0);
        chk("flush_count", bus.stall_count, 32'd1);

        // Reset asserted mid-stall
        id_set(1'b1, 4'b0001, 5'd1, 5'd5, 32'h10, 32'd0, 32'd4, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
        tick();
        id_set(1'b1, 4'b0100, 5'd5, 5'd6, 32'h50, 32'h60, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        chk("mid_stall_pre", 32'(bus.stall), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stall", 32'(bus.stall), 32'd0);
        chk("mid_rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("mid_rst_count", bus.stall_count, 32'd0);
        reset = 1'b1;
        tick();
        chk("post_rst_load", 32'(bus.ex_alu_ctrl), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
